// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback path.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/wb_entry_store.sv
// Pending-write storage: tail write port, head retire port, and all entries
// presented oldest-first so the forwarding logic can pick the youngest match.
module wb_entry_store
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_ptr,
    input  wb_entry_t        wr_entry,
    input  logic             rd_en,
    input  logic [PTR_W-1:0] rd_ptr,
    output wb_entry_t        head,
    output wb_entry_t        ordered [DEPTH]
);

    wb_entry_t mem [DEPTH];

    // Only valid bits are reset; payload is qualified by them. On a full-queue
    // push+pop the slot is the same, and the later write keeps it valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i].valid <= 1'b0;
            end
        end else begin
            if (rd_en) begin
                mem[rd_ptr].valid <= 1'b0;
            end
            if (wr_en) begin
                mem[wr_ptr] <= wr_entry;
            end
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_order
        assign ordered[k] = mem[rd_ptr + PTR_W'(k)];
    end

    assign head = ordered[0];

endmodule

// File: rtl/regfile_writeback_queue.sv
// Writeback queue in front of the 32x32 register file: FIFO of pending writes,
// one commit per cycle, with forwarding of uncommitted values to two read ports.
module regfile_writeback_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  WbValid,
    output logic                  WbReady,
    input  logic [REG_ADDR_W-1:0] WbRegister,
    input  logic [DATA_W-1:0]     WbData,
    input  logic                  Hold,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0]     WriteData,
    input  logic [REG_ADDR_W-1:0] ReadRegister1,
    input  logic [REG_ADDR_W-1:0] ReadRegister2,
    output logic                  Fwd1Hit,
    output logic [DATA_W-1:0]     Fwd1Data,
    output logic                  Fwd2Hit,
    output logic [DATA_W-1:0]     Fwd2Data,
    output logic [PTR_W:0]        Count,
    output logic                  Empty
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count_q;
    logic             push, pop;
    wb_entry_t        head, wr_entry;
    wb_entry_t        ordered [DEPTH];

    assign Empty    = (count_q == '0);
    assign Count    = count_q;
    assign pop      = !Empty && !Hold;
    assign WbReady  = (count_q < FULL_CNT) || pop;
    // Register 0 requests still handshake but never occupy a slot.
    assign push     = WbValid && WbReady && (WbRegister != ZERO_REG);
    assign wr_entry = '{valid: 1'b1, addr: WbRegister, data: WbData};

    assign RegWrite      = pop;
    assign WriteRegister = pop ? head.addr : ZERO_REG;
    assign WriteData     = pop ? head.data : '0;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    wb_entry_store #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_store (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .wr_en    (push),
        .wr_ptr   (wr_ptr),
        .wr_entry (wr_entry),
        .rd_en    (pop),
        .rd_ptr   (rd_ptr),
        .head     (head),
        .ordered  (ordered)
    );

    // Scan oldest to youngest so the youngest match wins; the head being
    // retired this cycle still hits because the file has not captured it yet.
    always_comb begin
        Fwd1Hit  = 1'b0;
        Fwd1Data = '0;
        Fwd2Hit  = 1'b0;
        Fwd2Data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (ordered[k].valid && ReadRegister1 != ZERO_REG &&
                ordered[k].addr == ReadRegister1) begin
                Fwd1Hit  = 1'b1;
                Fwd1Data = ordered[k].data;
            end
            if (ordered[k].valid && ReadRegister2 != ZERO_REG &&
                ordered[k].addr == ReadRegister2) begin
                Fwd2Hit  = 1'b1;
                Fwd2Data = ordered[k].data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue: reset, drain, hold, forwarding, r0, async reset.
module tb_regfile_writeback_queue;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        WbValid;
    logic        WbReady;
    logic [4:0]  WbRegister;
    logic [31:0] WbData;
    logic        Hold;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic        Fwd1Hit;
    logic [31:0] Fwd1Data;
    logic        Fwd2Hit;
    logic [31:0] Fwd2Data;
    logic [2:0]  Count;
    logic        Empty;

    int tests = 0;
    int fails = 0;

    regfile_writeback_queue #(.DEPTH(4), .PTR_W(2)) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .WbValid       (WbValid),
        .WbReady       (WbReady),
        .WbRegister    (WbRegister),
        .WbData        (WbData),
        .Hold          (Hold),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .Fwd1Hit       (Fwd1Hit),
        .Fwd1Data      (Fwd1Data),
        .Fwd2Hit       (Fwd2Hit),
        .Fwd2Data      (Fwd2Data),
        .Count         (Count),
        .Empty         (Empty)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    logic [4:0]  exp_reg [5];
    logic [31:0] exp_dat [5];

    initial begin
        Reset_n = 1'b1; WbValid = 1'b0; WbRegister = '0; WbData = '0;
        Hold = 1'b0; ReadRegister1 = '0; ReadRegister2 = '0;
        #1 Reset_n = 1'b0;
        #2;
        chk("rst_count", 32'(Count), 0);
        chk("rst_empty", 32'(Empty), 1);
        chk("rst_regwrite", 32'(RegWrite), 0);
        tick(); tick();
        Reset_n = 1'b1;
        #1;
        chk("rel_regwrite", 32'(RegWrite), 0);
        chk("rel_empty", 32'(Empty), 1);
        chk("rel_count", 32'(Count), 0);
        chk("rel_wbready", 32'(WbReady), 1);
        chk("rel_fwd1hit", 32'(Fwd1Hit), 0);

        // Single write with Hold low
        tick();
        WbValid = 1'b1; WbRegister = 5'd16; WbData = 32'd2467;
        #1;
        chk("single_ready", 32'(WbReady), 1);
        chk("single_pre_rw", 32'(RegWrite), 0);
        tick();
        WbValid = 1'b0; ReadRegister1 = 5'd16;
        #1;
        chk("single_rw", 32'(RegWrite), 1);
        chk("single_wreg", 32'(WriteRegister), 16);
        chk("single_wdata", WriteData, 2467);
        chk("single_fwd_popping", 32'(Fwd1Hit), 1);
        chk("single_fwd_data", Fwd1Data, 2467);
        tick();
        chk("single_after_rw", 32'(RegWrite), 0);
        chk("single_after_empty", 32'(Empty), 1);
        chk("single_after_wreg", 32'(WriteRegister), 0);
        chk("single_after_fwd", 32'(Fwd1Hit), 0);

        // Hold burst fills the queue, fifth request stalls
        Hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            WbValid = 1'b1; WbRegister = 5'(i); WbData = 32'h11 * i;
            tick();
        end
        WbRegister = 5'd6; WbData = 32'h66;
        #1;
        chk("burst_count", 32'(Count), 4);
        chk("burst_ready", 32'(WbReady), 0);
        chk("burst_hold_rw", 32'(RegWrite), 0);
        tick();
        chk("burst_stall_count", 32'(Count), 4);
        Hold = 1'b0;
        #1;
        chk("burst_drain_ready", 32'(WbReady), 1);
        exp_reg = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd6};
        exp_dat = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h66};
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("drain%0d_rw", i), 32'(RegWrite), 1);
            chk($sformatf("drain%0d_reg", i), 32'(WriteRegister), 32'(exp_reg[i]));
            chk($sformatf("drain%0d_data", i), WriteData, exp_dat[i]);
            tick();
            WbValid = 1'b0;
            if (i == 0) chk("drain_reuse_count", 32'(Count), 4);
            #1;
        end
        chk("drain_done_empty", 32'(Empty), 1);
        chk("drain_done_rw", 32'(RegWrite), 0);

        // Forwarding picks the youngest duplicate; r0 and unaccepted requests never hit
        Hold = 1'b1;
        WbValid = 1'b1; WbRegister = 5'd5; WbData = 32'hA;
        tick();
        WbData = 32'hB;
        tick();
        WbRegister = 5'd7; WbData = 32'h77;
        ReadRegister1 = 5'd5; ReadRegister2 = 5'd0;
        #1;
        chk("fwd_count", 32'(Count), 2);
        chk("fwd1_hit", 32'(Fwd1Hit), 1);
        chk("fwd1_data", Fwd1Data, 32'hB);
        chk("fwd2_r0_hit", 32'(Fwd2Hit), 0);
        chk("fwd2_r0_data", Fwd2Data, 0);
        ReadRegister2 = 5'd7;
        #1;
        chk("fwd2_incoming_hit", 32'(Fwd2Hit), 0);
        WbValid = 1'b0;
        Hold = 1'b0;
        #1;
        chk("fwd_drain0_data", WriteData, 32'hA);
        chk("fwd_drain0_fwd", Fwd1Data, 32'hB);
        tick();
        chk("fwd_drain1_data", WriteData, 32'hB);
        chk("fwd_drain1_fwd", Fwd1Data, 32'hB);
        tick();
        chk("fwd_done_hit", 32'(Fwd1Hit), 0);

        // Register 0 handshakes but is dropped
        WbValid = 1'b1; WbRegister = 5'd0; WbData = 32'hDEAD; ReadRegister1 = 5'd0;
        #1;
        chk("r0_ready", 32'(WbReady), 1);
        tick();
        WbValid = 1'b0;
        #1;
        chk("r0_count", 32'(Count), 0);
        chk("r0_rw", 32'(RegWrite), 0);
        chk("r0_fwd", 32'(Fwd1Hit), 0);
        tick();
        chk("r0_rw_later", 32'(RegWrite), 0);

        // Asynchronous reset discards queued writes
        Hold = 1'b1;
        for (int i = 8; i <= 10; i++) begin
            WbValid = 1'b1; WbRegister = 5'(i); WbData = 32'(i);
            tick();
        end
        WbValid = 1'b0; ReadRegister1 = 5'd8;
        #1;
        chk("mid_count", 32'(Count), 3);
        chk("mid_fwd", 32'(Fwd1Hit), 1);
        Hold = 1'b0; Reset_n = 1'b0;
        #1;
        chk("async_count", 32'(Count), 0);
        chk("async_rw", 32'(RegWrite), 0);
        chk("async_empty", 32'(Empty), 1);
        chk("async_fwd", 32'(Fwd1Hit), 0);
        tick();
        Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("post_rst%0d_rw", i), 32'(RegWrite), 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
